// File: rtl/npc_lsu_pkg.sv
// Shared constants and types for the NPC load/store port: opcodes, funct3
// encodings, fault codes and the port FSM state type.
package npc_lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment unit: decodes the memory op, flags illegal or
// misaligned accesses, builds store lanes/strobes and extracts load data.
module lsu_align
  import npc_lsu_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_off,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_store,
  output logic [1:0]  fault,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data
);

  logic        is_load;
  logic        legal;
  logic        half;
  logic        word;
  logic        misalign;
  logic [31:0] shifted;

  always_comb begin
    is_load    = (opcode == OPC_LOAD);
    is_store   = (opcode == OPC_STORE);
    legal      = 1'b0;
    half       = 1'b0;
    word       = 1'b0;
    wstrb      = 4'b0000;
    wdata_lane = wdata;

    if (is_load) begin
      case (funct3)
        F3_B, F3_BU: legal = 1'b1;
        F3_H, F3_HU: begin legal = 1'b1; half = 1'b1; end
        F3_W:        begin legal = 1'b1; word = 1'b1; end
        default:     legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        F3_B:    legal = 1'b1;
        F3_H:    begin legal = 1'b1; half = 1'b1; end
        F3_W:    begin legal = 1'b1; word = 1'b1; end
        default: legal = 1'b0;
      endcase
    end

    misalign = (half && addr_off[0]) || (word && (addr_off != 2'b00));

    // Illegal funct3 outranks misalignment; non-memory opcodes are never faulted.
    fault = FAULT_OK;
    if ((is_load || is_store) && !legal) fault = FAULT_ILLEGAL;
    else if ((is_load || is_store) && misalign) fault = FAULT_MISALIGN;

    is_mem = (is_load || is_store) && legal && !misalign;

    if (is_store && is_mem) begin
      case (funct3)
        F3_B: begin
          wstrb      = 4'b0001 << addr_off;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_H: begin
          wstrb      = 4'b0011 << addr_off;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_port.sv
// Load/store port between execute and the data-memory port: one instruction
// in flight, registered request/response handshakes, bounded wait for memory.
module lsu_port
  import npc_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [1:0]  out_fault,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its payload stay stable until that edge.

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [7:0]  timer_q;
  logic        req_wen_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_wstrb_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_off_q;
  logic [31:0] rdata_q;
  logic [1:0]  fault_q;

  logic        a_is_mem;
  logic        a_is_store;
  logic [1:0]  a_fault;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wdata;
  logic [31:0] a_load_data;
  logic        unused_inst_bits;

  assign unused_inst_bits = ^{in_inst[31:15], in_inst[11:7]};

  lsu_align u_align (
    .opcode     (in_inst[6:0]),
    .funct3     (in_inst[14:12]),
    .addr_off   (in_addr[1:0]),
    .wdata      (in_wdata),
    .ld_funct3  (ld_f3_q),
    .ld_off     (ld_off_q),
    .rdata      (mem_rsp_rdata),
    .is_mem     (a_is_mem),
    .is_store   (a_is_store),
    .fault      (a_fault),
    .wstrb      (a_wstrb),
    .wdata_lane (a_wdata),
    .load_data  (a_load_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = a_is_mem ? REQ : RESP;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid || (timer_q == TIMEOUT_CNT)) state_d = RESP;
      RESP: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= 8'd0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      req_wstrb_q <= 4'd0;
      ld_f3_q     <= 3'd0;
      ld_off_q    <= 2'd0;
      rdata_q     <= 32'd0;
      fault_q     <= FAULT_OK;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Fault and non-memory results are preset here and go straight to RESP.
            req_wen_q   <= a_is_mem && a_is_store;
            req_addr_q  <= {in_addr[31:2], 2'b00};
            req_wdata_q <= a_wdata;
            req_wstrb_q <= a_wstrb;
            ld_f3_q     <= in_inst[14:12];
            ld_off_q    <= in_addr[1:0];
            rdata_q     <= 32'd0;
            fault_q     <= a_fault;
          end
        end
        REQ: begin
          if (mem_req_ready) timer_q <= 8'd0;
        end
        WAIT: begin
          // A response in the expiry cycle still counts as a normal completion.
          if (mem_rsp_valid) begin
            rdata_q <= req_wen_q ? 32'd0 : a_load_data;
            fault_q <= FAULT_OK;
          end else if (timer_q == TIMEOUT_CNT) begin
            rdata_q <= 32'd0;
            fault_q <= FAULT_TIMEOUT;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign out_valid     = (state_q == RESP);
  assign mem_req_wen   = req_wen_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = req_wstrb_q;
  assign out_rdata     = rdata_q;
  assign out_fault     = fault_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_lsu_port.sv
// Bench for lsu_port: directed scenarios plus randomized traffic checked
// against a byte-addressed reference memory and an expected-result queue.
module tb_lsu_port;
  import npc_lsu_pkg::*;

  localparam int TO = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_fault;
  logic [1:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lsu_port #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_wen   (mem_req_wen),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_rdata     (out_rdata),
    .out_fault     (out_fault),
    .dbg_state     (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_count = 0;

  logic [33:0] exp_q[$];      // {fault, rdata}
  logic [31:0] mem_w [0:7];   // memory seen by the port
  logic [7:0]  ref_b [0:31];  // reference byte image

  always @(posedge clk) if (!rst && mem_req_valid && mem_req_ready) hs_count++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic preload(input int wi, input logic [31:0] w);
    mem_w[wi] = w;
    for (int j = 0; j < 4; j++) ref_b[wi*4 + j] = w[8*j +: 8];
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[6:0] = opc;
    r[14:12] = f3;
    return r;
  endfunction

  // Reference decode straight from the ISA rules: access size, signedness, fault.
  function automatic void classify(input logic [31:0] inst, input logic [31:0] addr,
                                   output logic is_mem, output logic is_store,
                                   output int size, output logic sgn, output logic [1:0] flt);
    is_mem = 1'b0; is_store = 1'b0; size = 0; sgn = 1'b0; flt = 2'b00;
    if (inst[6:0] == 7'b0000011) begin
      case (inst[14:12])
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end else if (inst[6:0] == 7'b0100011) begin
      is_store = 1'b1;
      case (inst[14:12])
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      return;
    end
    if (size == 0) flt = 2'b11;
    else if ((int'(addr[1:0]) % size) != 0) flt = 2'b01;
    else is_mem = 1'b1;
  endfunction

  // Full transaction: offer, serve memory with the given stalls, collect result.
  task automatic run_txn(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] wdata,
                         input int rdy_dly, input int rsp_dly, input int odly,
                         output int lat, output logic [31:0] obs_rdata, output logic [1:0] obs_fault);
    logic        is_mem, is_store, sgn, hs_wen;
    int          size, a, t0, wt, hs0, idx;
    logic [1:0]  flt;
    logic [3:0]  e_strb, hs_strb;
    logic [31:0] e_wdata, e_rdata, val, hs_wdata;
    logic [33:0] exp;
    classify(inst, addr, is_mem, is_store, size, sgn, flt);
    a = int'(addr[4:0]);
    idx = int'(addr[4:2]);
    e_strb = 4'b0000;
    e_wdata = wdata;
    if (is_store && is_mem) begin
      for (int j = 0; j < size; j++) e_strb[int'(addr[1:0]) + j] = 1'b1;
      for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    end
    val = 32'd0;
    if (is_mem && !is_store) begin
      for (int j = 0; j < size; j++) val = val | (32'(ref_b[a + j]) << (8*j));
      if (sgn && size < 4 && val[8*size - 1]) val = val | (32'hFFFF_FFFF << (8*size));
    end
    e_rdata = 32'd0;
    if (is_mem && rsp_dly > TO) flt = 2'b10;
    else if (is_mem && !is_store) e_rdata = val;
    exp_q.push_back({flt, e_rdata});

    wt = 0;
    while (in_ready !== 1'b1 && wt < 20) begin step(); wt++; end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_wait: in_ready=%b required=1", in_ready); end

    hs0 = hs_count;
    in_valid = 1'b1; in_inst = inst; in_addr = addr; in_wdata = wdata;
    t0 = cyc;
    step();
    in_valid = 1'b0; in_inst = $urandom; in_addr = $urandom; in_wdata = $urandom;

    if (is_mem) begin
      hs_wen = 1'b0; hs_strb = 4'b0; hs_wdata = 32'd0;
      for (int k = 0; k <= rdy_dly; k++) begin
        n_checks++;
        if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, in_ready, out_valid} !==
            {1'b1, is_store, addr[31:2], 2'b00, e_strb, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL req_fields: v=%b wen=%b addr=%h strb=%b rdy=%b ov=%b required v=1 wen=%b addr=%h strb=%b rdy=0 ov=0",
                   mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, in_ready, out_valid,
                   is_store, {addr[31:2], 2'b00}, e_strb);
        end
        if (is_store) begin
          n_checks++;
          if (mem_req_wdata !== e_wdata) begin
            n_fail++; $display("FAIL req_wdata: got %h required %h", mem_req_wdata, e_wdata);
          end
        end
        mem_req_ready = (k == rdy_dly);
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_rdata = $urandom;
        hs_wen = mem_req_wen; hs_strb = mem_req_wstrb; hs_wdata = mem_req_wdata;
        step();
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      if (hs_wen)
        for (int b = 0; b < 4; b++) if (hs_strb[b]) mem_w[idx][8*b +: 8] = hs_wdata[8*b +: 8];
      if (is_store)
        for (int j = 0; j < size; j++) ref_b[a + j] = wdata[8*j +: 8];

      for (int k = 0; k <= TO; k++) begin
        n_checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
          n_fail++; $display("FAIL wait_phase: out_valid=%b mem_req_valid=%b required 0 0", out_valid, mem_req_valid);
        end
        if (k == rsp_dly) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = is_store ? $urandom : mem_w[idx];
          step();
          mem_rsp_valid = 1'b0;
          break;
        end
        step();
      end
    end

    lat = cyc - t0;
    obs_rdata = out_rdata;
    obs_fault = out_fault;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL out_valid_arrival: got %b required 1", out_valid); end
    n_checks++;
    if (hs_count - hs0 !== (is_mem ? 1 : 0)) begin
      n_fail++; $display("FAIL req_count: got %0d handshakes required %0d", hs_count - hs0, is_mem ? 1 : 0);
    end

    exp = exp_q.pop_front();
    for (int k = 0; k <= odly; k++) begin
      n_checks++;
      if ({out_fault, out_rdata} !== exp) begin
        n_fail++; $display("FAIL result: fault=%b rdata=%h required fault=%b rdata=%h", out_fault, out_rdata, exp[33:32], exp[31:0]);
      end
      n_checks++;
      if ({out_valid, in_ready, mem_req_valid} !== 3'b100) begin
        n_fail++; $display("FAIL resp_hold: ov/ir/mv=%b required 100", {out_valid, in_ready, mem_req_valid});
      end
      out_ready = (k == odly);
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rsp_rdata = $urandom;
      step();
    end
    out_ready = 1'b0; mem_rsp_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL resp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step(); step(); step();
    n_checks++;
    if ({in_ready, mem_req_valid, mem_req_wen, out_valid} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctl: ir/mv/wen/ov=%b required 1000", {in_ready, mem_req_valid, mem_req_wen, out_valid});
    end
    n_checks++;
    if ({out_rdata, out_fault} !== 34'd0) begin
      n_fail++; $display("FAIL reset_out: rdata=%h fault=%b required 0 0", out_rdata, out_fault);
    end
    n_checks++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wstrb} !== 68'd0) begin
      n_fail++; $display("FAIL reset_req: addr=%h wdata=%h strb=%b required 0", mem_req_addr, mem_req_wdata, mem_req_wstrb);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_store_word();
    int lat; logic [31:0] r; logic [1:0] f;
    run_txn(mk_inst(7'b0100011, 3'd2), 32'h8000_0008, 32'h1122_3344, 0, 0, 0, lat, r, f);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d required 3", lat); end
    n_checks++;
    if (f !== 2'b00 || r !== 32'd0) begin n_fail++; $display("FAIL sw_result: fault=%b rdata=%h required 00 0", f, r); end
    n_checks++;
    if (mem_w[2] !== 32'h1122_3344) begin n_fail++; $display("FAIL sw_memory: got %h required 11223344", mem_w[2]); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] r; logic [1:0] f;
    preload(0, 32'h0000_0000);
    run_txn(mk_inst(7'b0100011, 3'd0), 32'h8000_0003, 32'h0000_00AB, 0, 0, 0, lat, r, f);
    n_checks++;
    if (mem_w[0] !== 32'hAB00_0000) begin n_fail++; $display("FAIL sb_memory: got %h required ab000000", mem_w[0]); end
    run_txn(mk_inst(7'b0000011, 3'd4), 32'h8000_0003, 32'h0, 0, 0, 0, lat, r, f);
    n_checks++;
    if (r !== 32'h0000_00AB) begin n_fail++; $display("FAIL lbu_value: got %h required 000000ab", r); end
    run_txn(mk_inst(7'b0000011, 3'd0), 32'h8000_0003, 32'h0, 1, 2, 1, lat, r, f);
    n_checks++;
    if (r !== 32'hFFFF_FFAB) begin n_fail++; $display("FAIL lb_value: got %h required ffffffab", r); end
  endtask

  task automatic test_faults();
    int lat; logic [31:0] r; logic [1:0] f;
    run_txn(mk_inst(7'b0000011, 3'd1), 32'h8000_0001, 32'h0, 0, 0, 0, lat, r, f);
    n_checks++;
    if (lat !== 1 || f !== 2'b01 || r !== 32'd0) begin
      n_fail++; $display("FAIL lh_misalign: lat=%0d fault=%b rdata=%h required 1 01 0", lat, f, r);
    end
    run_txn(mk_inst(7'b0000011, 3'd3), 32'h8000_0000, 32'h0, 0, 0, 1, lat, r, f);
    n_checks++;
    if (lat !== 1 || f !== 2'b11) begin n_fail++; $display("FAIL illegal_f3: lat=%0d fault=%b required 1 11", lat, f); end
    run_txn(mk_inst(7'b0110011, 3'd0), 32'h8000_0002, 32'h0, 0, 0, 0, lat, r, f);
    n_checks++;
    if (lat !== 1 || f !== 2'b00 || r !== 32'd0) begin
      n_fail++; $display("FAIL non_mem: lat=%0d fault=%b rdata=%h required 1 00 0", lat, f, r);
    end
  endtask

  task automatic test_stall();
    int lat; logic [31:0] r; logic [1:0] f;
    run_txn(mk_inst(7'b0000011, 3'd2), 32'h8000_0008, 32'h0, 5, 1, 3, lat, r, f);
    n_checks++;
    if (lat !== 9 || r !== 32'h1122_3344 || f !== 2'b00) begin
      n_fail++; $display("FAIL lw_stall: lat=%0d rdata=%h fault=%b required 9 11223344 00", lat, r, f);
    end
  endtask

  task automatic test_timeout();
    int lat; logic [31:0] r; logic [1:0] f;
    run_txn(mk_inst(7'b0000011, 3'd2), 32'h8000_0008, 32'h0, 0, TO + 3, 2, lat, r, f);
    n_checks++;
    if (lat !== 3 + TO || f !== 2'b10 || r !== 32'd0) begin
      n_fail++; $display("FAIL timeout: lat=%0d fault=%b rdata=%h required %0d 10 0", lat, f, r, 3 + TO);
    end
    run_txn(mk_inst(7'b0000011, 3'd2), 32'h8000_0008, 32'h0, 0, TO, 0, lat, r, f);
    n_checks++;
    if (r !== 32'h1122_3344 || f !== 2'b00) begin
      n_fail++; $display("FAIL after_timeout: rdata=%h fault=%b required 11223344 00", r, f);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] r; logic [1:0] f;
    preload(1, 32'h8001_1234);
    in_valid = 1'b1; in_inst = mk_inst(7'b0000011, 3'd2); in_addr = 32'h8000_0004; in_wdata = 32'h0;
    step();
    in_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    n_checks++;
    if (dbg_state !== WAIT) begin n_fail++; $display("FAIL mid_state: got %0d required WAIT", dbg_state); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, mem_req_valid} !== 3'b100 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL mid_reset: ir/ov/mv=%b state=%0d required 100 IDLE", {in_ready, out_valid, mem_req_valid}, dbg_state);
    end
    run_txn(mk_inst(7'b0000011, 3'd5), 32'h8000_0006, 32'h0, 0, 0, 0, lat, r, f);
    n_checks++;
    if (r !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_after_reset: got %h required 00008001", r); end
  endtask

  task automatic test_random();
    int lat, kind; logic [31:0] r, addr, inst; logic [1:0] f; logic [6:0] opc;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) opc = 7'b0000011;
      else if (kind < 8) opc = 7'b0100011;
      else begin
        opc = 7'($urandom);
        if (opc == 7'b0000011 || opc == 7'b0100011) opc = 7'b0010011;
      end
      inst = mk_inst(opc, 3'($urandom_range(0, 7)));
      addr = BASE + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_txn(inst, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, TO + 2),
              $urandom_range(0, 2), lat, r, f);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_addr = 32'd0; in_wdata = 32'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) preload(i, $urandom);
    test_reset();
    test_store_word();
    test_byte_lanes();
    test_faults();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
